counter_step_controller: RTL and testbench



---
 rtl/counter_step_controller.sv | 90 +++++++++
 tb/tb_counter_step_controller.sv | 110 +++++++++++
 2 files changed

// File: rtl/counter_step_controller.sv
// Converts two debounced push-buttons into en/up step strobes for an up/down counter.
// A press steps once, holding it auto-repeats, and conflicting presses are locked out.
module counter_step_controller #(
  parameter int DELAY  = 6000000,
  parameter int PERIOD = 1200000,
  parameter int W      = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic btnUp,
  input  logic btnDown,
  output logic en,
  output logic up,
  output logic repeating
);

  typedef enum logic [1:0] {IDLE, ARMED, REPEAT, LOCKOUT} state_t;

  localparam logic [W-1:0] DELAY_LAST  = W'(DELAY - 1);
  localparam logic [W-1:0] PERIOD_LAST = W'(PERIOD - 1);

  state_t         r_state;
  logic [W-1:0]   r_timer;
  logic           w_sel;
  logic           w_other;

  // The accepted button is identified by the direction latched when it was accepted.
  assign w_sel   = up ? btnUp   : btnDown;
  assign w_other = up ? btnDown : btnUp;

  // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      en        <= 1'b0;
      up        <= 1'b0;
      repeating <= 1'b0;
    end else begin
      en        <= 1'b0;
      repeating <= 1'b0;
      case (r_state)
        IDLE: begin
          if (btnUp ^ btnDown) begin
            en      <= 1'b1;
            up      <= btnUp;
            r_timer <= '0;
            r_state <= ARMED;
          end else if (btnUp && btnDown) begin
            r_state <= LOCKOUT;
          end
        end
        ARMED: begin
          if (!w_sel) begin
            r_state <= IDLE;
          end else if (w_other) begin
            r_state <= LOCKOUT;
          end else if (r_timer == DELAY_LAST) begin
            en        <= 1'b1;
            r_timer   <= '0;
            r_state   <= REPEAT;
            repeating <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!w_sel) begin
            r_state <= IDLE;
          end else if (w_other) begin
            r_state <= LOCKOUT;
          end else begin
            repeating <= 1'b1;
            if (r_timer == PERIOD_LAST) begin
              en      <= 1'b1;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        LOCKOUT: begin
          if (!btnUp && !btnDown) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_step_controller.sv
// Directed bench for counter_step_controller with DELAY=4, PERIOD=2, W=3.
// Each edge's expected en/up/repeating values are written out by hand.
module tb_counter_step_controller;

  logic clk;
  logic reset;
  logic btnUp;
  logic btnDown;
  logic en;
  logic up;
  logic repeating;

  int n_checks = 0;
  int n_pass   = 0;

  counter_step_controller #(.DELAY(4), .PERIOD(2), .W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .btnUp     (btnUp),
    .btnDown   (btnDown),
    .en        (en),
    .up        (up),
    .repeating (repeating)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply buttons, take one edge, then compare the registered outputs.
  task automatic edge_chk(input logic u, input logic d, input logic e_en, input logic e_up,
                          input logic e_rep, input string tag);
    btnUp   = u;
    btnDown = d;
    @(posedge clk);
    #1;
    check({tag, "_en"},  en,        e_en);
    check({tag, "_up"},  up,        e_up);
    check({tag, "_rep"}, repeating, e_rep);
  endtask

  initial begin
    reset = 1'b1; btnUp = 1'b1; btnDown = 1'b0;

    // 1: reset held two edges with btnUp pressed, then first step up.
    edge_chk(1, 0, 0, 0, 0, "t1_rst0");
    edge_chk(1, 0, 0, 0, 0, "t1_rst1");
    reset = 1'b0;
    edge_chk(1, 0, 1, 1, 0, "t1_first");
    edge_chk(0, 0, 0, 1, 0, "t1_rel");

    // 2: single tap, IDLE again at k+1 so a new press steps at k+2.
    edge_chk(1, 0, 1, 1, 0, "t2_tap");
    edge_chk(0, 0, 0, 1, 0, "t2_rel");
    edge_chk(0, 1, 1, 0, 0, "t2_down");
    edge_chk(0, 0, 0, 0, 0, "t2_rel2");

    // 3: btnDown held k..k+9: steps at k, k+4, k+6, k+8.
    for (int j = 0; j < 10; j++)
      edge_chk(0, 1, (j == 0 || j == 4 || j == 6 || j == 8), 0, (j >= 4),
               $sformatf("t3_j%0d", j));
    edge_chk(0, 0, 0, 0, 0, "t3_rel");

    // 5: simultaneous press locks out until both released; up stays 0.
    edge_chk(1, 1, 0, 0, 0, "t5_k0");
    edge_chk(1, 1, 0, 0, 0, "t5_k1");
    edge_chk(1, 1, 0, 0, 0, "t5_k2");
    edge_chk(0, 1, 0, 0, 0, "t5_k3");
    edge_chk(0, 1, 0, 0, 0, "t5_k4");
    edge_chk(0, 0, 0, 0, 0, "t5_k5");
    edge_chk(0, 0, 0, 0, 0, "t5_k6");
    edge_chk(1, 0, 1, 1, 0, "t5_k7");
    edge_chk(0, 0, 0, 1, 0, "t5_rel");

    // 4: release exactly on DELAY expiry: only the first step.
    for (int j = 0; j < 4; j++)
      edge_chk(1, 0, (j == 0), 1, 0, $sformatf("t4_j%0d", j));
    edge_chk(0, 0, 0, 1, 0, "t4_k4");
    edge_chk(0, 0, 0, 1, 0, "t4_k5");

    // 6: conflict while repeating -> LOCKOUT until both low.
    for (int j = 0; j < 5; j++)
      edge_chk(1, 0, (j == 0 || j == 4), 1, (j == 4), $sformatf("t6_j%0d", j));
    edge_chk(1, 1, 0, 1, 0, "t6_k5");
    edge_chk(1, 1, 0, 1, 0, "t6_k6");
    edge_chk(1, 1, 0, 1, 0, "t6_k7");
    edge_chk(0, 1, 0, 1, 0, "t6_k8");
    edge_chk(0, 0, 0, 1, 0, "t6_k9");
    edge_chk(0, 1, 1, 0, 0, "t6_k10");
    edge_chk(0, 0, 0, 0, 0, "t6_rel");

    // Reset mid-repeat with button held: outputs clear, then a fresh press.
    for (int j = 0; j < 6; j++)
      edge_chk(1, 0, (j == 0 || j == 4), 1, (j >= 4), $sformatf("t7_j%0d", j));
    reset = 1'b1;
    edge_chk(1, 0, 0, 0, 0, "t7_rst");
    reset = 1'b0;
    edge_chk(1, 0, 1, 1, 0, "t7_again");
    edge_chk(0, 0, 0, 1, 0, "t7_rel");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
